// File: rtl/lsu_subword_ctrl.sv
// Load/store unit between the core and a word-addressed data memory.
// Handles byte/half/word accesses with read-modify-write stores and extended loads.
module lsu_subword_ctrl #(
    parameter int unsigned IDX_W = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_WRITE,
        S_RESP
    } state_t;

    typedef struct packed {
        logic        we;
        logic [2:0]  funct3;
        logic [1:0]  off;
        logic [31:0] wdata;
    } req_t;

    state_t            state_q, state_d;
    req_t              cap_q, cap_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              we_q, we_d;
    logic [31:0]       wd_q, wd_d;
    logic              valid_q, valid_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;

    logic              acc_err;
    logic [7:0]        lane_b;
    logic [15:0]       lane_h;
    logic [31:0]       load_val;
    logic [31:0]       store_val;
    logic              unused_addr_bits;

    // Index bits above the memory size are dropped, so addresses wrap
    assign unused_addr_bits = ^req_addr[31:IDX_W+2];

    // Alignment and funct3 legality of the incoming request
    always_comb begin
        acc_err = 1'b0;
        case (req_funct3)
            F3_B:    acc_err = 1'b0;
            F3_H:    acc_err = req_addr[0];
            F3_W:    acc_err = |req_addr[1:0];
            F3_BU:   acc_err = req_we;
            F3_HU:   acc_err = req_we | req_addr[0];
            default: acc_err = 1'b1;
        endcase
    end

    // Lane extraction/extension for loads and lane merge for stores
    always_comb begin
        lane_b    = mem_rd[{cap_q.off, 3'b000} +: 8];
        lane_h    = cap_q.off[1] ? mem_rd[31:16] : mem_rd[15:0];
        load_val  = mem_rd;
        store_val = mem_rd;
        case (cap_q.funct3)
            F3_B:    load_val = {{24{lane_b[7]}}, lane_b};
            F3_BU:   load_val = {24'h000000, lane_b};
            F3_H:    load_val = {{16{lane_h[15]}}, lane_h};
            F3_HU:   load_val = {16'h0000, lane_h};
            default: load_val = mem_rd;
        endcase
        case (cap_q.funct3)
            F3_B: store_val[{cap_q.off, 3'b000} +: 8] = cap_q.wdata[7:0];
            F3_H: begin
                if (cap_q.off[1]) begin
                    store_val[31:16] = cap_q.wdata[15:0];
                end else begin
                    store_val[15:0] = cap_q.wdata[15:0];
                end
            end
            F3_W:    store_val = cap_q.wdata;
            default: store_val = mem_rd;
        endcase
    end

    assign req_ready = (state_q == S_IDLE) & rst;

    // Next state and next values of every registered output
    always_comb begin
        state_d = state_q;
        cap_d   = cap_q;
        idx_d   = idx_q;
        we_d    = 1'b0;
        wd_d    = 32'h0;
        valid_d = 1'b0;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    cap_d   = '{we: req_we, funct3: req_funct3,
                                off: req_addr[1:0], wdata: req_wdata};
                    rdata_d = 32'h0;
                    err_d   = acc_err;
                    if (acc_err) begin
                        valid_d = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        idx_d   = req_addr[IDX_W+1:2];
                        state_d = S_ACCESS;
                    end
                end
            end
            S_ACCESS: begin
                if (cap_q.we) begin
                    we_d    = 1'b1;
                    wd_d    = store_val;
                    state_d = S_WRITE;
                end else begin
                    rdata_d = load_val;
                    valid_d = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_WRITE: begin
                valid_d = 1'b1;
                state_d = S_RESP;
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cap_q   <= '0;
            idx_q   <= '0;
            we_q    <= 1'b0;
            wd_q    <= 32'h0;
            valid_q <= 1'b0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cap_q   <= cap_d;
            idx_q   <= idx_d;
            we_q    <= we_d;
            wd_q    <= wd_d;
            valid_q <= valid_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // A reset asserted during WRITE must suppress the pending write
    assign mem_we     = we_q & rst;
    assign mem_wd     = wd_q;
    assign mem_addr   = 32'(idx_q);
    assign resp_valid = valid_q;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_lsu_subword_ctrl.sv
// Directed bench for lsu_subword_ctrl with a 1024-word behavioural memory.
module tb_lsu_subword_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    logic [31:0] mem [1024];
    int n_checks = 0;
    int n_pass   = 0;

    lsu_subword_ctrl #(.IDX_W(10)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wd     (mem_wd),
        .mem_rd     (mem_rd)
    );

    always #5 clk = ~clk;

    assign mem_rd = mem[mem_addr[9:0]];

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[9:0]] <= mem_wd;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // Issue one request from a negedge; returns at the negedge after the response
    task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input int exp_lat, input logic [31:0] exp_rd,
                          input logic exp_err, input logic [31:0] exp_idx);
        int          lat = 0;
        int          wes = 0;
        logic [31:0] widx = 32'h0;
        logic [31:0] got_rd = 32'h0;
        logic        got_err = 1'b0;
        logic [31:0] got_idx = 32'h0;
        bit          got = 1'b0;
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        check({tag, "_ready"}, 32'(req_ready), 32'h1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int n = 1; n <= 8 && !got; n++) begin
            @(negedge clk);
            if (mem_we) begin
                wes++;
                widx = mem_addr;
            end
            if (resp_valid) begin
                got     = 1'b1;
                lat     = n;
                got_rd  = resp_rdata;
                got_err = resp_err;
                got_idx = mem_addr;
            end
        end
        check({tag, "_resp_seen"}, 32'(got), 32'h1);
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_rdata"}, got_rd, exp_rd);
        check({tag, "_err"}, 32'(got_err), 32'(exp_err));
        check({tag, "_we_pulses"}, 32'(wes), (we && !exp_err) ? 32'h1 : 32'h0);
        if (!exp_err) check({tag, "_mem_addr"}, got_idx, exp_idx);
        if (wes > 0) check({tag, "_write_idx"}, widx, exp_idx);
        @(negedge clk);
        check({tag, "_pulse_1cyc"}, 32'(resp_valid), 32'h0);
        check({tag, "_rdata_held"}, resp_rdata, exp_rd);
        check({tag, "_err_held"}, 32'(resp_err), 32'(exp_err));
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        rst        = 1'b0;
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'h10;
        req_wdata  = 32'hFFFF_FFFF;

        // Reset held with a request pending
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("rst_ready", 32'(req_ready), 32'h0);
            check("rst_mem_we", 32'(mem_we), 32'h0);
            check("rst_resp_valid", 32'(resp_valid), 32'h0);
        end
        check("rst_outputs", {mem_addr | mem_wd | resp_rdata}, 32'h0);
        check("rst_err", 32'(resp_err), 32'h0);
        req_valid = 1'b0;
        rst       = 1'b1;
        #1 check("rst_release_ready", 32'(req_ready), 32'h1);
        @(negedge clk);

        // Word store and load
        do_req("sw_10", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 3, 32'h0, 1'b0, 32'h4);
        check("mem4_deadbeef", mem[4], 32'hDEADBEEF);
        do_req("lw_10", 1'b0, 3'b010, 32'h10, 32'h0, 2, 32'hDEADBEEF, 1'b0, 32'h4);

        // Byte store merge and byte loads
        do_req("sw_base", 1'b1, 3'b010, 32'h10, 32'h11223344, 3, 32'h0, 1'b0, 32'h4);
        do_req("sb_12", 1'b1, 3'b000, 32'h12, 32'h000000AA, 3, 32'h0, 1'b0, 32'h4);
        check("mem4_merged_b", mem[4], 32'h11AA3344);
        do_req("lb_12", 1'b0, 3'b000, 32'h12, 32'h0, 2, 32'hFFFFFFAA, 1'b0, 32'h4);
        do_req("lbu_12", 1'b0, 3'b100, 32'h12, 32'h0, 2, 32'h000000AA, 1'b0, 32'h4);
        do_req("lb_10", 1'b0, 3'b000, 32'h10, 32'h0, 2, 32'h00000044, 1'b0, 32'h4);
        do_req("lh_10", 1'b0, 3'b001, 32'h10, 32'h0, 2, 32'h00003344, 1'b0, 32'h4);

        // Half store into the upper lane and half loads
        do_req("sh_16", 1'b1, 3'b001, 32'h16, 32'h12348001, 3, 32'h0, 1'b0, 32'h5);
        check("mem5_merged_h", mem[5], 32'h80010000);
        do_req("lh_16", 1'b0, 3'b001, 32'h16, 32'h0, 2, 32'hFFFF8001, 1'b0, 32'h5);
        do_req("lhu_16", 1'b0, 3'b101, 32'h16, 32'h0, 2, 32'h00008001, 1'b0, 32'h5);
        do_req("lw_14", 1'b0, 3'b010, 32'h14, 32'h0, 2, 32'h80010000, 1'b0, 32'h5);

        // Misaligned and illegal requests
        do_req("lw_13_mis", 1'b0, 3'b010, 32'h13, 32'h0, 1, 32'h0, 1'b1, 32'h0);
        do_req("sh_11_mis", 1'b1, 3'b001, 32'h11, 32'hFFFF, 1, 32'h0, 1'b1, 32'h0);
        do_req("st_f3_011", 1'b1, 3'b011, 32'h10, 32'h0, 1, 32'h0, 1'b1, 32'h0);
        do_req("st_f3_100", 1'b1, 3'b100, 32'h10, 32'h0, 1, 32'h0, 1'b1, 32'h0);
        do_req("ld_f3_110", 1'b0, 3'b110, 32'h10, 32'h0, 1, 32'h0, 1'b1, 32'h0);
        check("mem4_unchanged", mem[4], 32'h11AA3344);
        check("mem5_unchanged", mem[5], 32'h80010000);

        // Index wraps modulo 1024 words
        do_req("lw_wrap", 1'b0, 3'b010, 32'h0000_1010, 32'h0, 2, 32'h11AA3344, 1'b0, 32'h4);

        // Reset during the WRITE state of a byte store
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b000;
        req_addr   = 32'h13;
        req_wdata  = 32'h55;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("abort_access_we", 32'(mem_we), 32'h0);
        @(negedge clk);
        check("abort_write_we", 32'(mem_we), 32'h1);
        rst = 1'b0;
        #1 check("abort_we_gated", 32'(mem_we), 32'h0);
        @(negedge clk);
        check("abort_no_resp", 32'(resp_valid), 32'h0);
        check("abort_ready_low", 32'(req_ready), 32'h0);
        rst = 1'b1;
        #1 check("abort_idle_ready", 32'(req_ready), 32'h1);
        @(negedge clk);
        check("abort_no_resp2", 32'(resp_valid), 32'h0);
        check("abort_mem_kept", mem[4], 32'h11AA3344);
        do_req("lbu_13_after", 1'b0, 3'b100, 32'h13, 32'h0, 2, 32'h00000011, 1'b0, 32'h4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
